// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the RISC-V stage registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_FULL,
    PS_SKID
  } pipe_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/register_nbit.sv
// WIDTH-bit enabled register with asynchronous active-low reset to RST_VAL.
module register_nbit #(
  parameter int unsigned          WIDTH   = 32,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, 2-entry skid buffer, flush.
// All outputs decode from registered state, so no input-to-output comb path.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  pipe_state_e      state_q, state_d;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_d, main_q, skid_q;

  register_nbit #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  register_nbit #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (skid_en),
    .d     (skid_d),
    .q     (skid_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PS_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = in_data;
    skid_en = 1'b0;
    skid_d  = in_data;
    if (flush) begin
      state_d = PS_EMPTY;
      main_en = 1'b1;
      main_d  = FLUSH_VAL;
      skid_en = 1'b1;
      skid_d  = FLUSH_VAL;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_valid) begin
            main_en = 1'b1;
            state_d = PS_FULL;
          end
        end
        PS_FULL: begin
          if (in_valid && out_ready) begin
            main_en = 1'b1;
          end else if (in_valid) begin
            skid_en = 1'b1;
            state_d = PS_SKID;
          end else if (out_ready) begin
            state_d = PS_EMPTY;
          end
        end
        PS_SKID: begin
          // Upstream sees in_ready=0 here, so in_valid is deliberately ignored.
          if (out_ready) begin
            main_en = 1'b1;
            main_d  = skid_q;
            state_d = PS_FULL;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    occupancy = 2'd0;
    unique case (state_q)
      PS_FULL: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      PS_SKID: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  assign out_data = main_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised pipeline-stage register that generalises the fixed 8-bit enabled register into a WIDTH-bit stage with a valid/ready handshake, a 2-entry skid buffer, a synchronous flush and programmable reset and flush values. It sits between the stages of the 5-stage RISC-V pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). Stalls arrive as backpressure on out_ready and squashes arrive on flush. There is no combinational path from input to output or from out_ready to in_ready, so timing is isolated per stage.

Parameters:
WIDTH, 32, payload width in bits (at least 1)
RST_VAL, '0, value driven on out_data and held in both entries during and after reset
FLUSH_VAL, '0, value loaded into both entries on flush (for example 32'h0000_0013, a NOP, on instruction stages)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous squash, highest priority after reset
in_valid  in  1  upstream data valid
in_ready  out  1  stage can accept; registered, depends on state only
in_data  in  WIDTH  upstream payload
out_valid  out  1  main entry holds valid data
out_ready  in  1  downstream accepts
out_data  out  WIDTH  main entry contents
occupancy  out  2  number of valid entries: 0, 1 or 2

Behaviour:
- Reset (rst_n=0, asynchronous) takes effect immediately, mid-operation included.
  - state=EMPTY, out_valid=0, in_ready=1, occupancy=0.
  - main and skid entries = RST_VAL.
  - Any in-flight data is lost. The first accept is possible on the first rising edge after rst_n rises.
- Handshakes:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
  - Latency is 1 cycle from input to out_valid. Sustained throughput is 1 word per cycle while out_ready=1.
- States, with outputs for each:
  - EMPTY: out_valid=0, in_ready=1, occupancy=0.
  - FULL: out_valid=1, in_ready=1, occupancy=1.
  - SKID: out_valid=1, in_ready=0, occupancy=2.
- Transitions when flush=0:
  - EMPTY, in_valid: main<=in_data, go to FULL.
  - EMPTY, otherwise: hold.
  - FULL, in_valid & out_ready: main<=in_data, stay FULL (pass-through).
  - FULL, in_valid & !out_ready: skid<=in_data, go to SKID.
  - FULL, !in_valid & out_ready: go to EMPTY. main keeps its last value, so out_data is stable but meaningless.
  - FULL, neither: hold.
  - SKID, out_ready: main<=skid, go to FULL. in_valid is ignored because in_ready=0.
  - SKID, !out_ready: hold.
- Data stability: while out_valid=1 and out_ready=0, out_data must not change.
- Flush (rst_n=1, flush=1 at an edge):
  - Next state=EMPTY. main and skid are loaded with FLUSH_VAL.
  - An input transfer in the same cycle is discarded.
  - An output transfer in the same cycle still counts as completed.
  - in_ready=1 on the following cycle.
  - Flush held for several cycles keeps the stage EMPTY.
- in_valid during SKID: no effect. The upstream must hold its data, per the handshake.
- No X propagation: out_data always equals RST_VAL, FLUSH_VAL or previously accepted data.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {PS_EMPTY, PS_FULL, PS_SKID} pipe_state_e
  - localparam NOP_INSN = 32'h0000_0013, used by instruction-carrying stage instances as FLUSH_VAL.
- One natural sub-module, register_nbit: a WIDTH-bit enabled register with async active-low reset to RST_VAL. It is instantiated twice, for main and skid. Loading FLUSH_VAL is done by a mux on its D input.
- The control FSM stays in pipe_stage_reg.

Test Plan:
1. Reset, then stream in_data=1,2,3,4 with in_valid=1 and out_ready=1 -> out_data=1,2,3,4 on consecutive cycles, each 1 cycle after its input; in_ready stays 1; occupancy=1.
2. Load 0xA, then hold out_ready=0 and present 0xB -> SKID, in_ready=0, occupancy=2, out_data stays 0xA. Raise out_ready -> 0xA then 0xB delivered, no loss or duplication.
3. Stall in SKID for 5 cycles while in_data toggles to 0xC/0xD with in_valid=1 -> out_data held at 0xA; 0xC and 0xD never appear (upstream not ready).
4. In SKID with FLUSH_VAL=32'h13, pulse flush while also presenting in_valid=1 and in_data=0xE -> next cycle EMPTY, out_valid=0, out_data=32'h13, in_ready=1, occupancy=0, 0xE dropped.
5. Assert rst_n=0 asynchronously mid-cycle while in FULL -> out_valid=0 and out_data=RST_VAL before the next clock edge. Release -> first accept on the next edge.
6. Randomised in_valid/out_ready for 10k cycles with a scoreboard -> in-order, lossless delivery; out_data stable while stalled; in_ready never asserted with occupancy=2.
